// File: rtl/ntt_fault_pkg.sv
// Shared types and default widths for the NTT modular-multiplier fault checker.
package ntt_fault_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_LATENCY   = 3;
  localparam int DEF_IDX_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 8;

  // Encoding 2'd3 is deliberately left unused; the checker recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } fault_state_e;

endpackage

// File: rtl/shiftreg.sv
// Fixed-depth register pipeline with synchronous clear; DEPTH must be at least 1.
module shiftreg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: every stage is cleared, not just the first, so beats in flight at reset never emerge.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/modmul_fault_checker.sv
// Compares primary and redundant modmul results, streams checked results and raises a sticky alarm.
// Define FAULT_RANGE_CHECK_EN to also flag a primary result that is not reduced below mod_q.
module modmul_fault_checker
  import ntt_fault_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IDX_WIDTH-1:0] in_idx,
  input  logic [WIDTH-1:0]     mod_q,
  input  logic [WIDTH-1:0]     out_o,
  input  logic [WIDTH-1:0]     out_o_fault,
  input  logic                 clr,
  output logic                 res_valid,
  output logic [WIDTH-1:0]     res_data,
  output logic [IDX_WIDTH-1:0] res_idx,
  output logic                 fault_pulse,
  output logic                 fault_flag,
  output logic [IDX_WIDTH-1:0] fault_idx,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  output logic                 halt,
  output logic [1:0]           state
);

  logic [IDX_WIDTH:0]   dly_in;
  logic [IDX_WIDTH:0]   dly_out;
  logic                 chk_valid;
  logic [IDX_WIDTH-1:0] chk_idx;
  logic                 mismatch;

  fault_state_e         state_q;
  fault_state_e         state_d;

  logic                 res_valid_d;
  logic [WIDTH-1:0]     res_data_d;
  logic [IDX_WIDTH-1:0] res_idx_d;
  logic                 fault_pulse_d;
  logic                 fault_flag_d;
  logic [IDX_WIDTH-1:0] fault_idx_d;
  logic [CNT_WIDTH-1:0] fault_cnt_d;
  logic                 halt_d;

  // Valid and index travel together so they stay aligned with the multiplier pipeline.
  assign dly_in = {in_valid, in_idx};

  shiftreg #(
    .WIDTH (IDX_WIDTH + 1),
    .DEPTH (LATENCY)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d   (dly_in),
    .q   (dly_out)
  );

  assign chk_valid = dly_out[IDX_WIDTH];
  assign chk_idx   = dly_out[IDX_WIDTH-1:0];

`ifdef FAULT_RANGE_CHECK_EN
  assign mismatch = chk_valid && ((out_o != out_o_fault) || (out_o >= mod_q));
`else
  logic unused_mod_q;
  assign unused_mod_q = ^mod_q;
  assign mismatch     = chk_valid && (out_o != out_o_fault);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (chk_valid) state_d = mismatch ? ALARM : MONITOR;
      MONITOR: if (mismatch) state_d = ALARM;
      ALARM:   if (clr && !mismatch) state_d = MONITOR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: each output takes a default before the case so no path leaves it unassigned (no latch).
    res_valid_d   = 1'b0;
    res_data_d    = res_data;
    res_idx_d     = res_idx;
    fault_pulse_d = mismatch;
    fault_flag_d  = fault_flag;
    fault_idx_d   = fault_idx;
    halt_d        = halt;
    fault_cnt_d   = fault_cnt;
    if (mismatch && (fault_cnt != '1)) fault_cnt_d = fault_cnt + CNT_WIDTH'(1);

    case (state_q)
      IDLE, MONITOR: begin
        if (mismatch) begin
          fault_flag_d = 1'b1;
          fault_idx_d  = chk_idx;
          halt_d       = 1'b1;
        end else if (chk_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = out_o;
          res_idx_d   = chk_idx;
        end
      end
      ALARM: begin
        // A new failure outranks the acknowledge and re-points fault_idx at the newest beat.
        if (mismatch) begin
          if (clr) fault_idx_d = chk_idx;
        end else if (clr) begin
          fault_flag_d = 1'b0;
          fault_idx_d  = '0;
          halt_d       = 1'b0;
        end
      end
      default: begin
        fault_flag_d = 1'b0;
        fault_idx_d  = '0;
        halt_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
      fault_pulse <= 1'b0;
      fault_flag  <= 1'b0;
      fault_idx   <= '0;
      fault_cnt   <= '0;
      halt        <= 1'b0;
    end else begin
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_idx     <= res_idx_d;
      fault_pulse <= fault_pulse_d;
      fault_flag  <= fault_flag_d;
      fault_idx   <= fault_idx_d;
      fault_cnt   <= fault_cnt_d;
      halt        <= halt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_modmul_fault_checker.sv
// Scoreboard bench: directed beats push hand-computed responses, a negedge monitor pops and compares.
module tb_modmul_fault_checker;

  localparam int W  = 16;
  localparam int IW = 8;
  localparam int Q  = 7681;
`ifdef FAULT_RANGE_CHECK_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_idx = '0;
  logic [W-1:0]  mod_q = W'(Q);
  logic [W-1:0]  out_o = '0;
  logic [W-1:0]  out_o_fault = '0;
  logic          clr = 1'b0;

  logic          res_valid, fault_pulse, fault_flag, halt;
  logic [W-1:0]  res_data;
  logic [IW-1:0] res_idx, fault_idx;
  logic [7:0]    fault_cnt;
  logic [1:0]    state;

  logic          s_res_valid, s_fault_pulse, s_fault_flag, s_halt;
  logic [W-1:0]  s_res_data;
  logic [IW-1:0] s_res_idx, s_fault_idx;
  logic [1:0]    s_fault_cnt;
  logic [1:0]    s_state;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit is_fault;
    int data;
    int idx;
    int flag;
    int fidx;
    int cnt;
    int halt;
    int st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  modmul_fault_checker #(.WIDTH(W), .LATENCY(3), .IDX_WIDTH(IW), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .mod_q(mod_q),
    .out_o(out_o), .out_o_fault(out_o_fault), .clr(clr),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .fault_pulse(fault_pulse), .fault_flag(fault_flag), .fault_idx(fault_idx),
    .fault_cnt(fault_cnt), .halt(halt), .state(state)
  );

  modmul_fault_checker #(.WIDTH(W), .LATENCY(3), .IDX_WIDTH(IW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .mod_q(mod_q),
    .out_o(out_o), .out_o_fault(out_o_fault), .clr(clr),
    .res_valid(s_res_valid), .res_data(s_res_data), .res_idx(s_res_idx),
    .fault_pulse(s_fault_pulse), .fault_flag(s_fault_flag), .fault_idx(s_fault_idx),
    .fault_cnt(s_fault_cnt), .halt(s_halt), .state(s_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(bit f, int d, int i, int flag, int fidx, int cnt, int h, int st);
    exp_t e;
    e.is_fault = f; e.data = d; e.idx = i; e.flag = flag;
    e.fidx = fidx; e.cnt = cnt; e.halt = h; e.st = st;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat: operands issued now, results presented LATENCY cycles later, optional clr alongside.
  task automatic beat(input int idx, input int o, input int of, input bit clr_c,
                      input bit has_exp, input exp_t e);
    if (has_exp) sb.push_back(e);
    in_valid = 1'b1; in_idx = IW'(idx);
    tick();
    in_valid = 1'b0; in_idx = '0;
    tick();
    tick();
    out_o = W'(o); out_o_fault = W'(of); clr = clr_c;
    tick();
    out_o = '0; out_o_fault = '0; clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
    check({tag, "_res_idx"}, int'(res_idx), 0);
    check({tag, "_fault_pulse"}, int'(fault_pulse), 0);
    check({tag, "_fault_flag"}, int'(fault_flag), 0);
    check({tag, "_fault_idx"}, int'(fault_idx), 0);
    check({tag, "_fault_cnt"}, int'(fault_cnt), 0);
    check({tag, "_halt"}, int'(halt), 0);
    check({tag, "_sat_cnt"}, int'(s_fault_cnt), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid || fault_pulse) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", int'({res_valid, fault_pulse}), 0);
        end else begin
          e = sb.pop_front();
          check("sb_res_valid", int'(res_valid), e.is_fault ? 0 : 1);
          check("sb_fault_pulse", int'(fault_pulse), e.is_fault ? 1 : 0);
          if (!e.is_fault) begin
            check("sb_res_data", int'(res_data), e.data);
            check("sb_res_idx", int'(res_idx), e.idx);
          end
          check("sb_fault_flag", int'(fault_flag), e.flag);
          check("sb_fault_idx", int'(fault_idx), e.fidx);
          check("sb_fault_cnt", int'(fault_cnt), e.cnt);
          check("sb_halt", int'(halt), e.halt);
          check("sb_state", int'(state), e.st);
          check("sb_sat_cnt", int'(s_fault_cnt), (e.cnt > 3) ? 3 : e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0);

    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // First beat out of IDLE: matching products pass through and move to MONITOR.
    beat(5, 1234, 1234, 1'b0, 1'b1, mk(0, 1234, 5, 0, 0, 0, 0, 1));
    beat(9, 1234, 1235, 1'b0, 1'b1, mk(1, 0, 0, 1, 9, 1, 1, 2));
    // Mismatch plus clr in ALARM: mismatch wins, fault_idx moves to 12.
    beat(12, 500, 501, 1'b1, 1'b1, mk(1, 0, 0, 1, 12, 2, 1, 2));

    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_state", int'(state), 1);
    check("clr_flag", int'(fault_flag), 0);
    check("clr_halt", int'(halt), 0);
    check("clr_fault_idx", int'(fault_idx), 0);
    check("clr_cnt_kept", int'(fault_cnt), 2);

    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_in_monitor_state", int'(state), 1);

    // Product equal to q: only the range check treats it as a fault.
`ifdef FAULT_RANGE_CHECK_EN
    beat(20, Q, Q, 1'b0, 1'b1, mk(1, 0, 0, 1, 20, 3, 1, 2));
    clr = 1'b1; tick(); clr = 1'b0;
    check("range_clr_state", int'(state), 1);
`else
    beat(20, Q, Q, 1'b0, 1'b1, mk(0, Q, 20, 0, 0, 2, 0, 1));
`endif

    beat(30, 10, 11, 1'b0, 1'b1, mk(1, 0, 0, 1, 30, 3 + RC, 1, 2));
    beat(31, 10, 12, 1'b0, 1'b1, mk(1, 0, 0, 1, 30, 4 + RC, 1, 2));
    beat(33, 100, 100, 1'b0, 1'b0, none);
    check("alarm_match_state", int'(state), 2);
    check("alarm_match_no_res", int'(res_valid), 0);
    beat(32, 0, 1, 1'b0, 1'b1, mk(1, 0, 0, 1, 30, 5 + RC, 1, 2));
    tick();
    check("cnt_total", int'(fault_cnt), 5 + RC);
    check("cnt_saturated", int'(s_fault_cnt), 3);
    check("pulse_one_cycle", int'(fault_pulse), 0);

    clr = 1'b1; tick(); clr = 1'b0;
    check("pre_rst_state", int'(state), 1);

    // Reset one cycle after issue: the in-flight beat must vanish.
    in_valid = 1'b1; in_idx = IW'(40);
    tick();
    in_valid = 1'b0; in_idx = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    out_o = W'(1); out_o_fault = W'(2);
    tick();
    out_o = '0; out_o_fault = '0;
    tick(); tick();
    check_all_zero("midrst");

    beat(7, 50, 50, 1'b0, 1'b1, mk(0, 50, 7, 0, 0, 0, 0, 1));
    tick(); tick();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
